// File: rtl/mux_scan_if.sv
// Handshake bundle between the 8:1 mux scan controller and its mux/consumer side.
// The master drives start/cont/stop, the mux output and frame_ready; the slave is the controller.
interface mux_scan_if;
  logic       start;
  logic       cont;
  logic       stop;
  logic       y;
  logic       frame_ready;
  logic [2:0] sel;
  logic [7:0] frame;
  logic       frame_valid;
  logic       busy;
  logic       overrun;

  modport master (
    output start, cont, stop, y, frame_ready,
    input  sel, frame, frame_valid, busy, overrun
  );

  modport slave (
    input  start, cont, stop, y, frame_ready,
    output sel, frame, frame_valid, busy, overrun
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps an 8:1 mux select, dwelling DWELL cycles per channel, and assembles the samples into a frame.
// Optional MUX_SCAN_OVERRUN_EN: continuous scans overwrite a blocked frame and flag overrun.
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input logic       clk,
  input logic       rst,
  mux_scan_if.slave bus
);
  // IDLE: waiting for start | SCAN: stepping sel | HOLD: frame complete, output slot busy
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [3:0] LAST = 4'(DWELL - 1);

  state_t     r_state, w_state;
  logic [2:0] r_sel, w_sel;
  logic [3:0] r_cnt, w_cnt;
  logic [7:0] r_shadow, w_shadow;
  logic [7:0] r_frame, w_frame;
  logic       r_fv, w_fv;
  logic       r_cont, w_cont;
  logic       r_stop, w_stop;
  logic       w_stop_seen, w_slot_free, w_again, w_load;

`ifdef MUX_SCAN_OVERRUN_EN
  logic       r_overrun, w_overrun;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sel    <= 3'd0;
      r_cnt    <= 4'd0;
      r_shadow <= 8'd0;
      r_frame  <= 8'd0;
      r_fv     <= 1'b0;
      r_cont   <= 1'b0;
      r_stop   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_sel    <= w_sel;
      r_cnt    <= w_cnt;
      r_shadow <= w_shadow;
      r_frame  <= w_frame;
      r_fv     <= w_fv;
      r_cont   <= w_cont;
      r_stop   <= w_stop;
    end
  end

`ifdef MUX_SCAN_OVERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_overrun <= 1'b0;
    else     r_overrun <= w_overrun;
  end
  assign bus.overrun = r_overrun;
`else
  assign bus.overrun = 1'b0;
`endif

  always_comb begin
    w_state     = r_state;
    w_sel       = r_sel;
    w_cnt       = r_cnt;
    w_shadow    = r_shadow;
    w_frame     = r_frame;
    w_fv        = r_fv & ~bus.frame_ready;
    w_cont      = r_cont;
    w_stop      = r_stop;
    w_stop_seen = r_stop | bus.stop;
    w_slot_free = ~r_fv | bus.frame_ready;
    w_again     = r_cont & ~w_stop_seen;
    w_load      = 1'b0;
`ifdef MUX_SCAN_OVERRUN_EN
    w_overrun   = r_overrun;
`endif

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state = SCAN;
          w_sel   = 3'd0;
          w_cnt   = 4'd0;
          w_cont  = bus.cont;
          w_stop  = 1'b0;
        end
      end
      SCAN: begin
        w_stop = w_stop_seen;
        if (r_cnt == LAST) begin
          w_cnt           = 4'd0;
          w_sel           = r_sel + 3'd1;
          w_shadow[r_sel] = bus.y;
          if (r_sel == 3'd7) begin
            if (w_slot_free) w_load = 1'b1;
`ifdef MUX_SCAN_OVERRUN_EN
            else if (w_again) begin
              w_load    = 1'b1;
              w_overrun = 1'b1;
            end
`endif
            else begin
              w_state = HOLD;
              w_sel   = 3'd7;
            end
          end
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      HOLD: begin
        w_stop = w_stop_seen;
        if (w_slot_free) w_load = 1'b1;
      end
      default: w_state = IDLE;
    endcase

    // The shadow already holds the final sample here, whether completing from SCAN or HOLD.
    if (w_load) begin
      w_frame = w_shadow;
      w_fv    = 1'b1;
      w_sel   = 3'd0;
      w_cnt   = 4'd0;
      w_state = w_again ? SCAN : IDLE;
    end
  end

  assign bus.sel         = r_sel;
  assign bus.frame       = r_frame;
  assign bus.frame_valid = r_fv;
  assign bus.busy        = (r_state != IDLE);
endmodule
